uart_frame_echo: RTL and testbench
==================================

Name: uart_frame_echo

Overview:
Parametrised UART frame-echo engine: receives FRAME_BYTES asynchronous serial bytes on rx into an internal buffer, then retransmits them on tx in arrival order.
- busy is high for the whole retransmission; rx is ignored while busy.
- Successor to the fixed 4-byte/9600-baud echo block.
- Adds 16x-oversampled start validation, mid-bit sampling, stop-bit checking with error flagging, configurable width/depth, and optional parity.
- Sits between the board rx/tx pins and the host side of the design.

Parameters:
FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, rx sample ticks per bit (power of 2, >=8)
DATA_BITS, 8, data bits per character (5..9)
FRAME_BYTES, 4, characters buffered before echo (1..64)

Ports:
clk  in  1  system clock, all logic on rising edge
nrst  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk, idle high
tx  out  1  serial output, idle high
busy  out  1  high while the buffered frame is being retransmitted
frame_err  out  1  one-clk pulse when a received character fails its stop check (or parity check)
rx_count  out  $clog2(FRAME_BYTES+1)  characters currently buffered

Behaviour:
- Reset values: tx=1, busy=0, frame_err=0, rx_count=0. Both FSMs go to IDLE, all counters clear, buffer contents are don't-care. Reset asserted mid-frame forces tx high immediately (async).
- Tick generator: DIV = FREQ/(BAUD*OVERSAMPLE), truncating (78 at defaults). Counter runs 0..DIV-1 and emits a 1-clk tick at DIV-1. TX bit period = DIV*OVERSAMPLE clocks (1248 at defaults).
- rx passes through a 2-flop synchroniser, plus one history flop for edge detect. All rx decisions use the synchronised value.
- RX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
  - IDLE: on a falling edge of synced rx while busy=0, clear the sample counter and enter START.
  - START: at sample OVERSAMPLE/2-1, if rx=1 it is a glitch, return to IDLE with no flag; else reset the sample counter and enter DATA.
  - DATA: sample every OVERSAMPLE ticks at mid-bit, LSB first, shifting into the character register. After DATA_BITS samples go to STOP.
  - STOP: mid-bit sample. If 1, write the character to buffer[wr_ptr], then wr_ptr++ and rx_count++. If 0, pulse frame_err, discard the character, leave rx_count unchanged. Either way go to IDLE.
- When a write makes rx_count==FRAME_BYTES, busy rises on the next clk. The RX FSM is held in IDLE while busy=1.
- TX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP, looping per character:
  - Leaves IDLE the clk after busy rises. TX uses its own bit-period counter, restarted at frame start, so bits are full periods.
  - tx is driven from a register (glitch-free).
  - Per character: start bit 0, then DATA_BITS LSB first, then one stop bit 1. Characters are sent back-to-back, buffer[0] first.
  - At the end of the last stop bit, in the same clk: busy=0, rx_count=0, pointers=0, TX returns to IDLE.
- After busy falls, a new frame needs a fresh falling edge on rx. A line that is still low does not start reception.
- Simultaneous events: frame_err and a buffer write never occur in the same clk. rx activity while busy is ignored entirely and produces no frame_err.
- Width rules: the data buffer is FRAME_BYTES x DATA_BITS. Pointers are $clog2(FRAME_BYTES) bits, with FRAME_BYTES=1 treated as 1 bit. Counters never wrap silently: rx_count saturates at FRAME_BYTES because RX is blocked.

Optional Feature:
UART_PARITY_EN
- Defined: an even-parity bit is inserted after the data bits on both rx and tx.
  - RX checks parity at mid-bit. On mismatch it pulses frame_err and discards the character, even if the stop bit is good.
  - TX appends the computed even parity.
- Undefined: no parity state or logic exists; frames are start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg holds:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP) shared by RX and TX.
  - Constant functions: clog2 and baud divisor.
  - Default FREQ/BAUD/OVERSAMPLE localparams.
- One sub-module, uart_baud_tick (params FREQ, BAUD, OVERSAMPLE; ports clk, nrst, clr, tick), instantiated twice: once for RX oversample ticks, once for TX with OVERSAMPLE=1.

Test Plan:
1. Defaults, send 0x53 0x6E 0x61 0x70 at 9600 -> busy rises 1 clk after the 4th stop sample; tx emits the same 4 bytes LSB-first at 1248 clk/bit; busy falls at the end of the last stop bit; rx_count goes 1,2,3,4,0.
2. 2 us low glitch on idle rx -> no character, frame_err=0, rx_count=0.
3. Byte 0xA5 sent with stop bit=0 -> frame_err pulses once, rx_count unchanged; next good byte is accepted normally.
4. Bytes driven on rx while busy=1 -> ignored; after busy falls the echoed frame equals only the first 4 bytes; no frame_err.
5. nrst low midway through the 2nd echoed byte -> tx=1 immediately, busy=0, rx_count=0; a fresh 4-byte frame then echoes correctly.
6. UART_PARITY_EN with DATA_BITS=7, FRAME_BYTES=2: 0x41 with wrong parity -> frame_err, discarded; 0x41 and 0x42 with correct parity -> echoed with parity bits 0 and 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, default rates and constant helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_FREQ       = 12000000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Clocks per oversample tick, truncating
    function automatic int baud_div(input int freq, input int baud, input int oversample);
        return freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a one-clk tick every FREQ/(BAUD*OVERSAMPLE) clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int FREQ       = DEF_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = baud_div(FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1; clr restarts the period so the first tick lands a full period later
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr || cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_frame_echo.sv
// rtl/uart_frame_echo.sv - buffers FRAME_BYTES rx characters then echoes them on tx; UART_PARITY_EN adds even parity
module uart_frame_echo
    import uart_pkg::*;
#(
    parameter int FREQ        = DEF_FREQ,
    parameter int BAUD        = DEF_BAUD,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int DATA_BITS   = 8,
    parameter int FRAME_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             rx,
    output logic                             tx,
    output logic                             busy,
    output logic                             frame_err,
    output logic [$clog2(FRAME_BYTES+1)-1:0] rx_count
);

    localparam int CNT_W   = clog2(FRAME_BYTES + 1);
    localparam int PTR_W   = (FRAME_BYTES == 1) ? 1 : clog2(FRAME_BYTES);
    localparam int SMP_W   = clog2(OVERSAMPLE);
    localparam int BIT_W   = clog2(DATA_BITS);
    // TX period is the rx tick period times OVERSAMPLE, so both sides share the truncated divisor
    localparam int TX_FREQ = baud_div(FREQ, BAUD, OVERSAMPLE) * OVERSAMPLE * BAUD;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_BYTES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [SMP_W-1:0] MID_START = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] MID_BIT   = SMP_W'(OVERSAMPLE - 1);

`ifdef UART_PARITY_EN
    localparam uart_state_t AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_t AFTER_DATA = ST_STOP;
`endif

    logic                 rx_meta, rx_sync, rx_hist, rx_fall;
    uart_state_t          rx_state, rx_next, tx_state, tx_next;
    logic                 rx_tick, tx_tick, rx_go, rx_mid, stop_ok;
    logic                 wr_en, err_d, tx_done, tx_d;
    logic [SMP_W-1:0]     smp_cnt;
    logic [BIT_W-1:0]     rx_bit, tx_bit;
    logic [DATA_BITS-1:0] rx_sh, tx_char;
    logic [DATA_BITS-1:0] buf_mem [FRAME_BYTES];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;

    uart_baud_tick #(.FREQ(FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_rx_tick (
        .clk(clk), .nrst(nrst), .clr(rx_go), .tick(rx_tick)
    );

    uart_baud_tick #(.FREQ(TX_FREQ), .BAUD(BAUD), .OVERSAMPLE(1)) u_tx_tick (
        .clk(clk), .nrst(nrst), .clr(tx_state == ST_IDLE), .tick(tx_tick)
    );

    // Two-flop synchroniser plus history flop; idle-high reset avoids a false edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_hist <= rx_sync;
        end
    end

    assign rx_fall = rx_hist && !rx_sync;
    assign rx_go   = (rx_state == ST_IDLE) && rx_fall && !busy;
    assign rx_mid  = rx_tick && (smp_cnt == ((rx_state == ST_START) ? MID_START : MID_BIT));

    // RX state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) rx_state <= ST_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next state: mid-bit samples drive every transition after the start edge
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:   if (rx_go) rx_next = ST_START;
            ST_START:  if (rx_mid) rx_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_mid && rx_bit == LAST_BIT) rx_next = AFTER_DATA;
`ifdef UART_PARITY_EN
            ST_PARITY: if (rx_mid) rx_next = ST_STOP;
`endif
            ST_STOP:   if (rx_mid) rx_next = ST_IDLE;
            default:   rx_next = ST_IDLE;
        endcase
    end

    // RX outputs: the stop sample either stores the character or flags it, never both
    always_comb begin
        wr_en = 1'b0;
        err_d = 1'b0;
        if (rx_state == ST_STOP && rx_mid) begin
            if (stop_ok) wr_en = 1'b1;
            else         err_d = 1'b1;
        end
    end

    // RX datapath: sample counter, bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            smp_cnt <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            if (rx_go || rx_mid)  smp_cnt <= '0;
            else if (rx_tick)     smp_cnt <= smp_cnt + 1'b1;
            if (rx_state == ST_START) begin
                rx_bit <= '0;
            end else if (rx_state == ST_DATA && rx_mid) begin
                rx_bit <= rx_bit + 1'b1;
                rx_sh  <= {rx_sync, rx_sh[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    logic par_bad;

    // Latch the even-parity verdict so a good stop bit cannot rescue a bad character
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                par_bad <= 1'b0;
        else if (rx_state == ST_PARITY && rx_mid) par_bad <= (^rx_sh) ^ rx_sync;
    end

    assign stop_ok = rx_sync && !par_bad;
`else
    assign stop_ok = rx_sync;
`endif

    // Character buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_ptr] <= rx_sh;
    end

    // Frame bookkeeping: busy follows a full buffer by one clk and clears with the last stop bit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr    <= '0;
            rx_count  <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_d;
            if (tx_done) begin
                wr_ptr   <= '0;
                rx_count <= '0;
                busy     <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    rx_count <= rx_count + 1'b1;
                end
                if (rx_count == CNT_W'(FRAME_BYTES)) busy <= 1'b1;
            end
        end
    end

    // TX state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tx_state <= ST_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state: characters loop back to START until the last one is sent
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:   if (busy) tx_next = ST_START;
            ST_START:  if (tx_tick) tx_next = ST_DATA;
            ST_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_next = AFTER_DATA;
`ifdef UART_PARITY_EN
            ST_PARITY: if (tx_tick) tx_next = ST_STOP;
`endif
            ST_STOP:   if (tx_tick) tx_next = (rd_ptr == LAST_PTR) ? ST_IDLE : ST_START;
            default:   tx_next = ST_IDLE;
        endcase
    end

    // TX outputs: next line level and end-of-frame strobe
    always_comb begin
        tx_char = buf_mem[rd_ptr];
        tx_done = (tx_state == ST_STOP) && tx_tick && (rd_ptr == LAST_PTR);
        case (tx_state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_char[tx_bit];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = ^tx_char;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // TX datapath: registered line output, bit index and read pointer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx     <= 1'b1;
            tx_bit <= '0;
            rd_ptr <= '0;
        end else begin
            tx <= tx_d;
            if (tx_state == ST_START)                tx_bit <= '0;
            else if (tx_state == ST_DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
            if (tx_done)                             rd_ptr <= '0;
            else if (tx_state == ST_STOP && tx_tick) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_frame_echo.sv
// tb/tb_uart_frame_echo.sv - scoreboard bench for uart_frame_echo (default build or UART_PARITY_EN)
module tb_uart_frame_echo;

    localparam int FREQ = 12000000;
    localparam int BAUD = 200000;
    localparam int OS   = 16;
`ifdef UART_PARITY_EN
    localparam int DB = 7;
    localparam int FB = 2;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int FB = 4;
    localparam int PB = 0;
`endif
    localparam int BIT = (FREQ / (BAUD * OS)) * OS;
    localparam int NB  = DB + 2 + PB;
    localparam int CW  = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          rx = 1'b1;
    logic          tx, busy, frame_err;
    logic [CW-1:0] rx_count;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    int echo_cnt = 0;
    int rst_cnt = 0;
    int busy_cur = 0;
    int busy_len = 0;
    logic [31:0] sb [$];
    logic        tx_prev = 1'b1;

    uart_frame_echo #(
        .FREQ(FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB), .FRAME_BYTES(FB)
    ) dut (
        .clk(clk), .nrst(nrst), .rx(rx), .tx(tx),
        .busy(busy), .frame_err(frame_err), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_of(input logic [8:0] d);
        logic [31:0] e;
        logic p;
        e = '0;
        p = 1'b0;
        for (int i = 0; i < DB; i++) begin
            e[i] = d[i];
            p = p ^ d[i];
        end
        if (PB != 0) e[DB] = p;
        return e;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [8:0] d, input logic stop_b, input logic par_flip);
        logic p;
        p = 1'b0;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            p = p ^ d[i];
            wait_clks(BIT);
        end
        if (PB != 0) begin
            rx = p ^ par_flip;
            wait_clks(BIT);
        end
        rx = stop_b;
        wait_clks(BIT);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [8:0] d);
        sb.push_back(exp_of(d));
        send_char(d, 1'b1, 1'b0);
    endtask

    task automatic wait_busy(input logic val, input int budget);
        int n;
        n = 0;
        while (busy !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(val ? "busy_rise" : "busy_fall", busy, val);
    endtask

    task automatic end_frame(input int echo_start);
        wait_busy(1'b0, FB * NB * BIT + 4 * BIT);
        @(negedge clk);
        @(negedge clk);
        check_val("count_clear", rx_count, 0);
        check_val("busy_len", busy_len, FB * NB * BIT + 1);
        check_val("echo_count", echo_cnt - echo_start, FB);
        check_val("sb_drained", sb.size(), 0);
    endtask

    task automatic mon_char();
        int r0;
        logic [31:0] got;
        logic [31:0] exp;
        r0 = rst_cnt;
        got = '0;
        repeat (BIT / 2) @(negedge clk);
        if (rst_cnt != r0) return;
        check_val("tx_start", tx, 1'b0);
        check_val("tx_busy", busy, 1'b1);
        for (int i = 0; i < DB + PB; i++) begin
            repeat (BIT) @(negedge clk);
            if (rst_cnt != r0) return;
            got[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        if (rst_cnt != r0) return;
        check_val("tx_stop", tx, 1'b1);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEADBEEF;
        check_val("echo_char", got, exp);
        echo_cnt++;
    endtask

    always @(negedge nrst) rst_cnt++;

    initial begin : frame_err_mon
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    initial begin : busy_mon
        forever begin
            @(negedge clk);
            if (!nrst) begin
                busy_cur = 0;
            end else if (busy === 1'b1) begin
                busy_cur++;
            end else if (busy_cur != 0) begin
                busy_len = busy_cur;
                busy_cur = 0;
            end
        end
    end

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (nrst && tx_prev && tx === 1'b0) mon_char();
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    logic [8:0] t1 [4] = '{9'h053, 9'h06E, 9'h061, 9'h070};
    logic [8:0] t3 [4] = '{9'h03C, 9'h011, 9'h0FE, 9'h080};
    logic [8:0] t5 [4] = '{9'h012, 9'h034, 9'h056, 9'h078};

    initial begin : stim
        int e0;
        int ec;
        int n;
        wait_clks(5);
        nrst = 1'b1;
        @(negedge clk);
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_frame_err", frame_err, 1'b0);
        check_val("rst_count", rx_count, 0);
        wait_clks(2);
`ifdef UART_PARITY_EN
        e0 = err_cnt;
        ec = echo_cnt;
        send_char(9'h041, 1'b1, 1'b1);
        wait_clks(BIT);
        check_val("par_err_pulse", err_cnt - e0, 1);
        check_val("par_discard", rx_count, 0);
        send_byte(9'h041);
        check_val("par_count1", rx_count, 1);
        send_byte(9'h042);
        wait_busy(1'b1, 2 * BIT);
        check_val("par_full", rx_count, FB);
        end_frame(ec);
        check_val("par_no_extra_err", err_cnt - e0, 1);
`else
        // Basic frame
        ec = echo_cnt;
        for (int i = 0; i < 4; i++) begin
            send_byte(t1[i]);
            check_val("t1_count", rx_count, i + 1);
        end
        wait_busy(1'b1, 2 * BIT);
        end_frame(ec);

        // Short glitch on idle line
        e0 = err_cnt;
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(3 * BIT);
        check_val("glitch_err", err_cnt - e0, 0);
        check_val("glitch_count", rx_count, 0);

        // Bad stop bit, then good frame with traffic while busy
        e0 = err_cnt;
        ec = echo_cnt;
        send_char(9'h0A5, 1'b0, 1'b0);
        wait_clks(BIT);
        check_val("stop_err_pulse", err_cnt - e0, 1);
        check_val("stop_err_count", rx_count, 0);
        for (int i = 0; i < 4; i++) begin
            send_byte(t3[i]);
            check_val("t3_count", rx_count, i + 1);
        end
        wait_busy(1'b1, 2 * BIT);
        send_char(9'h0FF, 1'b1, 1'b0);
        send_char(9'h000, 1'b1, 1'b0);
        check_val("busy_ignore_count", rx_count, FB);
        rx = 1'b0;
        end_frame(ec);
        wait_clks(3 * BIT);
        rx = 1'b1;
        wait_clks(3 * BIT);
        check_val("low_line_no_rx", rx_count, 0);
        check_val("busy_ignore_err", err_cnt - e0, 1);

        // Reset during the second echoed character
        ec = echo_cnt;
        for (int i = 0; i < 4; i++) send_byte(t1[i]);
        wait_busy(1'b1, 2 * BIT);
        n = 0;
        while (echo_cnt == ec && n < 2 * NB * BIT) begin
            @(negedge clk);
            n++;
        end
        check_val("first_echo", echo_cnt - ec, 1);
        n = 0;
        while (tx !== 1'b0 && n < 2 * BIT) begin
            @(negedge clk);
            n++;
        end
        check_val("second_start", tx, 1'b0);
        repeat (BIT / 4) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check_val("async_tx", tx, 1'b1);
        check_val("async_busy", busy, 1'b0);
        check_val("async_count", rx_count, 0);
        sb.delete();
        wait_clks(3);
        nrst = 1'b1;
        wait_clks(2);
        ec = echo_cnt;
        for (int i = 0; i < 4; i++) send_byte(t5[i]);
        wait_busy(1'b1, 2 * BIT);
        check_val("post_rst_full", rx_count, FB);
        end_frame(ec);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
